// File: rtl/imem_arb_pkg.sv
// Shared types and default widths for the instruction-memory arbiter.
// The FSM state, response-owner tag and starvation-counter width live here.
package imem_arb_pkg;

  localparam int unsigned IMEM_ADDR_W     = 32;
  localparam int unsigned IMEM_DATA_W     = 32;
  localparam int unsigned IMEM_MAX_LBURST = 4;
  localparam int unsigned LCNT_W          = 4;

  typedef enum logic {
    BOOT,
    RUN
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_LOAD
  } owner_e;

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating count of consecutive loader grants taken while fetch waits.
// Held at zero during boot; clear has priority over increment.
module imem_starve_ctr
  import imem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = IMEM_MAX_LBURST
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic hold_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam logic [LCNT_W-1:0] LimitVal = LCNT_W'(LIMIT);

  logic [LCNT_W-1:0] cnt_q;
  logic [LCNT_W-1:0] cnt_d;
  logic              at_limit;

  assign at_limit   = (cnt_q == LimitVal);
  assign at_limit_o = at_limit;

  always_comb begin
    cnt_d = cnt_q;
    if (hold_i || clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_limit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single-port instruction memory between fetch and the loader.
// Loader-only during boot; in run the loader wins unless fetch hit the starvation bound.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = IMEM_ADDR_W,
  parameter int unsigned DATA_W     = IMEM_DATA_W,
  parameter int unsigned MAX_LBURST = IMEM_MAX_LBURST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_release,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              fetch_stall,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  arb_state_e state_q;
  arb_state_e state_d;
  owner_e     owner_q;
  owner_e     owner_d;
  logic       f_gnt_c;
  logic       l_gnt_c;
  logic       at_limit;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (state_q == BOOT && boot_release) begin
      state_d = RUN;
    end
  end

  // Grant outputs, forced off while reset is asserted
  always_comb begin
    f_gnt_c = 1'b0;
    l_gnt_c = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        BOOT: begin
          l_gnt_c = l_req;
        end
        RUN: begin
          l_gnt_c = l_req & ~(f_req & at_limit);
          f_gnt_c = f_req & ~l_gnt_c;
        end
        default: begin
          f_gnt_c = 1'b0;
          l_gnt_c = 1'b0;
        end
      endcase
    end
  end

  assign f_gnt       = f_gnt_c;
  assign l_gnt       = l_gnt_c;
  assign fetch_stall = rst_n & f_req & ~f_gnt_c;

  imem_starve_ctr #(
    .LIMIT (MAX_LBURST)
  ) u_starve_ctr (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .hold_i     (state_q == BOOT),
    .inc_i      (l_gnt_c & f_req),
    .clr_i      (f_gnt_c | ~f_req),
    .at_limit_o (at_limit)
  );

  always_comb begin
    m_en    = f_gnt_c | l_gnt_c;
    m_we    = l_we & l_gnt_c;
    m_addr  = '0;
    m_wdata = '0;
    if (l_gnt_c) begin
      m_addr  = l_addr;
      m_wdata = l_wdata;
    end else if (f_gnt_c) begin
      m_addr  = f_addr;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (f_gnt_c) begin
      owner_d = OWN_FETCH;
    end else if (l_gnt_c && !l_we) begin
      owner_d = OWN_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Gating with rst_n drops a response whose read was granted just before reset
  assign f_rvalid = rst_n & (owner_q == OWN_FETCH);
  assign l_rvalid = rst_n & (owner_q == OWN_LOAD);
  assign f_rdata  = f_rvalid ? m_rdata : '0;
  assign l_rdata  = l_rvalid ? m_rdata : '0;

endmodule
